// File: rtl/entity_attr_bank_pkg.sv
// Shared constants, attribute record and commit FSM states for entity_attr_bank.
// The optional collision feature is enabled with ENTITY_COLLIDE_EN.
package entity_pkg;

   localparam int NUM_ENT  = 8;
   localparam int SEL_W    = 3;
   localparam int COORD_W  = 10;
   localparam int FLAG_W   = 4;
   localparam int ENT_SIZE = 16;

   typedef struct packed {
      logic [COORD_W-1:0] x;
      logic [COORD_W-1:0] y;
      logic [FLAG_W-1:0]  flags;
   } entity_attr_t;

   typedef enum logic {
      IDLE = 1'b0,
      COPY = 1'b1
   } commit_state_t;

   // One extra bit keeps the unsigned distance exact across the whole coordinate range.
   function automatic logic [COORD_W:0] abs_diff(input logic [COORD_W-1:0] a,
                                                 input logic [COORD_W-1:0] b);
      return (a >= b) ? ({1'b0, a} - {1'b0, b}) : ({1'b0, b} - {1'b0, a});
   endfunction

endpackage

// File: rtl/entity_attr_bank_if.sv
// Bus bundle of entity_attr_bank: CPU write port, vsync, renderer read port and status.
interface entity_attr_bank_if;
   import entity_pkg::*;

   logic [SEL_W-1:0]   entity_sel;
   logic [COORD_W-1:0] wr_x;
   logic [COORD_W-1:0] wr_y;
   logic [FLAG_W-1:0]  wr_flags;
   logic               wr_strobe;
   logic               vsync;
   logic [SEL_W-1:0]   rd_idx;
   logic [COORD_W-1:0] rd_x;
   logic [COORD_W-1:0] rd_y;
   logic [FLAG_W-1:0]  rd_flags;
   logic               commit_busy;
   logic [15:0]        frame_cnt;
   logic [NUM_ENT-1:0] collide;

   modport master (
      output entity_sel, wr_x, wr_y, wr_flags, wr_strobe, vsync, rd_idx,
      input  rd_x, rd_y, rd_flags, commit_busy, frame_cnt, collide
   );

   modport slave (
      input  entity_sel, wr_x, wr_y, wr_flags, wr_strobe, vsync, rd_idx,
      output rd_x, rd_y, rd_flags, commit_busy, frame_cnt, collide
   );

endinterface

// File: rtl/entity_attr_bank_overlap_chk.sv
// Combinational bounding-box overlap test between two entities (geometry only, no
// visibility). Used by entity_attr_bank when ENTITY_COLLIDE_EN is defined.
module entity_overlap_chk
   import entity_pkg::*;
(
   input  entity_attr_t i_a,
   input  entity_attr_t i_b,
   output logic         o_hit
);

   localparam logic [COORD_W:0] LP_SIZE = (COORD_W + 1)'(ENT_SIZE);

   logic [COORD_W:0] w_dx;
   logic [COORD_W:0] w_dy;

   assign w_dx  = abs_diff(i_a.x, i_b.x);
   assign w_dy  = abs_diff(i_a.y, i_b.y);
   assign o_hit = (w_dx < LP_SIZE) && (w_dy < LP_SIZE);

endmodule

// File: rtl/entity_attr_bank.sv
// Shadow/active entity attribute table with a vsync-triggered one-entry-per-cycle commit.
// Define ENTITY_COLLIDE_EN to add per-frame overlap flags against entity 0.
module entity_attr_bank
   import entity_pkg::*;
(
   input  logic              clk,
   input  logic              reset_n,
   entity_attr_bank_if.slave io_bus
);

   entity_attr_t       r_shadow [NUM_ENT];
   entity_attr_t       r_active [NUM_ENT];
   logic               r_strobe_q;
   logic               r_vsync_q;
   commit_state_t      r_state;
   commit_state_t      w_state_nxt;
   logic [SEL_W-1:0]   r_cnt;
   logic [SEL_W-1:0]   w_cnt_nxt;
   logic [15:0]        r_frame_cnt;
   entity_attr_t       r_rd;
   logic [NUM_ENT-1:0] w_collide;

   logic w_wr_fire;
   logic w_vsync_rise;
   logic w_copy_en;
   logic w_copy_last;

   assign w_wr_fire    = io_bus.wr_strobe & ~r_strobe_q;
   assign w_vsync_rise = io_bus.vsync & ~r_vsync_q;
   assign w_copy_en    = (r_state == COPY);
   assign w_copy_last  = w_copy_en && (r_cnt == SEL_W'(NUM_ENT - 1));

   // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         r_state <= IDLE;
         r_cnt   <= '0;
      end else begin
         r_state <= w_state_nxt;
         r_cnt   <= w_cnt_nxt;
      end
   end

   // NOTE: defaults first so no path through this block leaves a target unassigned (no latches).
   always_comb begin
      w_state_nxt = r_state;
      w_cnt_nxt   = r_cnt;
      unique case (r_state)
         IDLE: begin
            if (w_vsync_rise) begin
               w_state_nxt = COPY;
               w_cnt_nxt   = '0;
            end
         end
         COPY: begin
            w_cnt_nxt = r_cnt + 1'b1;
            if (w_copy_last) begin
               w_state_nxt = IDLE;
               w_cnt_nxt   = '0;
            end
         end
         default: begin
            w_state_nxt = IDLE;
            w_cnt_nxt   = '0;
         end
      endcase
   end

   // NOTE: both tables are reset because a reset mid-commit must leave no stale entity visible.
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         for (int i = 0; i < NUM_ENT; i++) begin
            r_shadow[i] <= '0;
            r_active[i] <= '0;
         end
      end else begin
         if (w_wr_fire) begin
            r_shadow[io_bus.entity_sel] <= entity_attr_t'{x:     io_bus.wr_x,
                                                          y:     io_bus.wr_y,
                                                          flags: io_bus.wr_flags};
         end
         // A same-index write this edge is not visible here, so the old shadow value commits.
         if (w_copy_en) begin
            r_active[r_cnt] <= r_shadow[r_cnt];
         end
      end
   end

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         r_strobe_q  <= 1'b0;
         r_vsync_q   <= 1'b0;
         r_frame_cnt <= '0;
         r_rd        <= '0;
      end else begin
         r_strobe_q <= io_bus.wr_strobe;
         r_vsync_q  <= io_bus.vsync;
         r_rd       <= r_active[io_bus.rd_idx];
         if (w_copy_last) begin
            r_frame_cnt <= r_frame_cnt + 16'd1;
         end
      end
   end

`ifdef ENTITY_COLLIDE_EN
   logic [NUM_ENT-1:0] r_scratch;
   logic [NUM_ENT-1:0] r_collide;
   logic [NUM_ENT-1:0] w_hit_vec;
   logic               w_geom_hit;
   logic               w_hit;

   // From cnt=1 on, active[0] already holds this frame's entity 0.
   entity_overlap_chk u_overlap (
      .i_a   (r_active[0]),
      .i_b   (r_shadow[r_cnt]),
      .o_hit (w_geom_hit)
   );

   assign w_hit     = w_geom_hit & r_active[0].flags[0] & r_shadow[r_cnt].flags[0] &
                      (r_cnt != '0);
   assign w_hit_vec = NUM_ENT'(w_hit) << r_cnt;

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         r_scratch <= '0;
         r_collide <= '0;
      end else if (w_copy_en) begin
         r_scratch <= (r_cnt == '0) ? '0 : (r_scratch | w_hit_vec);
         if (w_copy_last) begin
            r_collide <= r_scratch | w_hit_vec;
         end
      end
   end

   assign w_collide = r_collide;
`else
   assign w_collide = '0;
`endif

   assign io_bus.rd_x        = r_rd.x;
   assign io_bus.rd_y        = r_rd.y;
   assign io_bus.rd_flags    = r_rd.flags;
   assign io_bus.commit_busy = w_copy_en;
   assign io_bus.frame_cnt   = r_frame_cnt;
   assign io_bus.collide     = w_collide;

endmodule
